muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for MIPS MULT/MULTU/DIV/DIVU.
- Time-shares one existing 32-bit ripple adder (adder_) across every arithmetic step: operand negation, shift-add multiply, restoring divide and sign fix-up.
- Sits beside the ALU; owns the HI/LO result registers read by MFHI/MFLO.
- Fixed latency for every op, so the stall logic stays trivial.

---
 rtl/muldiv_sequencer_pkg.sv | 29 ++
 rtl/adder_.sv | 12 +
 rtl/muldiv_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings and default sizes for the MULT/DIV sequencer.
// Replaces a muldiv_defs.vh-style header with a package imported by each file.
package muldiv_sequencer_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_RUN    = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  function automatic logic op_is_signed(input logic [1:0] o);
    return o[0];
  endfunction

endpackage

// File: rtl/adder_.sv
// Plain 32-bit adder with carry-in, combinational, no flow control.
// Carry-out is not exported; callers derive it from the operand and sum MSBs.
module adder_ (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  assign sum = a + b + {31'b0, cin};

endmodule

// File: rtl/muldiv_sequencer.sv
// MULT/MULTU/DIV/DIVU sequencer on one shared adder; fixed WIDTH+4 edges accept-to-done, start ignored while busy.
// Optional MULDIV_ABORT_EN adds an abort input that returns a busy sequencer to IDLE without touching hi/lo.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             carry_q, carry_d, dbz_q, dbz_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum, rem_sh, q_sh, hi_fin;
  logic             add_cin, cout, shift_bit, is_div_op, b_zero, abort_hit;

`ifdef MULDIV_ABORT_EN
  assign abort_hit = abort && (state_q != S_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign is_div_op = op_q[1];
  assign b_zero    = (b_q == '0);
  assign shift_bit = acc_hi_q[WIDTH-1];
  assign rem_sh    = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  assign q_sh      = {acc_lo_q[WIDTH-2:0], 1'b0};

  adder_ u_adder (.a(add_a), .b(add_b), .cin(add_cin), .sum(add_sum));

  assign cout = (add_a[WIDTH-1] & add_b[WIDTH-1]) |
                ((add_a[WIDTH-1] ^ add_b[WIDTH-1]) & ~add_sum[WIDTH-1]);

  // Adder operand steering: every arithmetic step of every state goes through u_adder.
  always_comb begin
    add_a   = acc_hi_q;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_NEG_A: begin
        if (op_is_signed(op_q) && acc_lo_q[WIDTH-1]) begin
          add_a = '0; add_b = ~acc_lo_q; add_cin = 1'b1;
        end else begin
          add_a = acc_lo_q;
        end
      end
      S_NEG_B: begin
        if (op_is_signed(op_q) && b_q[WIDTH-1]) begin
          add_a = '0; add_b = ~b_q; add_cin = 1'b1;
        end else begin
          add_a = b_q;
        end
      end
      S_RUN: begin
        if (is_div_op) begin
          add_a = rem_sh; add_b = ~b_q; add_cin = 1'b1;
        end else begin
          add_a = acc_hi_q; add_b = acc_lo_q[0] ? b_q : '0;
        end
      end
      S_FIX_LO: begin
        if (neg_res_q) begin
          add_a = '0; add_b = ~acc_lo_q; add_cin = 1'b1;
        end else begin
          add_a = acc_lo_q;
        end
      end
      S_FIX_HI: begin
        if (op_q == OP_MULT && neg_res_q) begin
          add_a = ~acc_hi_q; add_cin = carry_q;
        end else if (neg_rem_q) begin
          add_a = '0; add_b = ~acc_hi_q; add_cin = 1'b1;
        end else begin
          add_a = acc_hi_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_NEG_A;
      S_NEG_A:  state_d = S_NEG_B;
      S_NEG_B:  state_d = S_RUN;
      S_RUN:    if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX_LO;
      S_FIX_LO: state_d = S_FIX_HI;
      S_FIX_HI: state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  always_comb begin
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    carry_d   = carry_q;
    dbz_d     = dbz_q;
    hi_fin    = add_sum;
    cnt_d     = (state_q == S_RUN && cnt_q != CNT_W'(WIDTH-1)) ? cnt_q + 1'b1 : '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op_e'(op);
          a_d       = a;
          b_d       = b;
          acc_lo_d  = a;
          acc_hi_d  = '0;
          carry_d   = 1'b0;
          neg_res_d = op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_rem_d = (op == OP_DIV) & a[WIDTH-1];
        end
      end
      S_NEG_A: begin
        acc_lo_d = add_sum;
        acc_hi_d = '0;
      end
      S_NEG_B: b_d = add_sum;
      S_RUN: begin
        if (is_div_op) begin
          // The shifted-out bit means the 33-bit partial remainder already exceeds |b|.
          if (shift_bit | cout) begin
            acc_hi_d = add_sum;
            acc_lo_d = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            acc_hi_d = rem_sh;
            acc_lo_d = q_sh;
          end
        end else begin
          acc_hi_d = {cout, add_sum[WIDTH-1:1]};
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
      end
      S_FIX_LO: begin
        carry_d  = cout;
        acc_lo_d = (is_div_op && b_zero) ? '1 : add_sum;
      end
      S_FIX_HI: begin
        if (is_div_op && b_zero) hi_fin = a_q;
        acc_hi_d = hi_fin;
        if (!abort_hit) begin
          hi_d  = hi_fin;
          lo_d  = acc_lo_q;
          dbz_d = is_div_op & b_zero;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    hi          = hi_q;
    lo          = lo_q;
    div_by_zero = dbz_q & (state_q == S_IDLE || state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= OP_MULTU;
      a_q       <= '0;
      b_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      carry_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      carry_q   <= carry_d;
      dbz_q     <= dbz_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes model results, a negedge monitor checks each done pulse.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;
`ifdef MULDIV_ABORT_EN
  logic        abort = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   inflight = 1'b0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: 64-bit arithmetic with MIPS truncating division semantics.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] up;
    longint      sx, sy, sp, sq, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.dbz = 1'b0;
    e.cyc = 0;
    case (o)
      2'b00: begin
        up = {32'b0, x} * {32'b0, y};
        e.hi = up[63:32]; e.lo = up[31:0];
      end
      2'b01: begin
        sp = sx * sy;
        e.hi = sp[63:32]; e.lo = sp[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = x; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else begin
          sq = sx / sy; sr = sx % sy;
          e.lo = sq[31:0]; e.hi = sr[31:0];
        end
      end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (inflight) chk("busy_during_op", 32'(busy), 32'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("hi", hi, e.hi);
          chk("lo", lo, e.lo);
          chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
          chk("latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  // poke_k pulses start again k negedges after the accept; rst_k asserts reset there instead.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke_k, input int rst_k);
    exp_t e;
    bit   seen;
    e = model(o, x, y);
    e.cyc = cyc + 1 + 36;
    exp_q.push_back(e);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; inflight = 1'b1;
    a = $urandom; b = $urandom; op = ~o;
    seen = 1'b0;
    for (int k = 1; k <= 50 && !seen; k++) begin
      @(negedge clk);
      start = (k == poke_k);
      if (k == rst_k) begin
        inflight = 1'b0;
        exp_q.delete();
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        return;
      end
      if (done) seen = 1'b1;
    end
    inflight = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within 50 cycles, expected done at cycle %0d", e.cyc);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 20));
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 0, 0);
    issue(2'b10, 32'd100, 32'd7, 0, 0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0);
    issue(2'b10, 32'd5, 32'd0, 0, 0);
    issue(2'b00, 32'd2, 32'd3, 0, 0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd0, 0, 0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 15, 0);
    repeat (60) @(negedge clk);

    issue(2'b01, 32'h1234_5678, 32'hFEDC_BA98, 0, 13);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b00, 32'd6, 32'd7, 0, 0);

    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
